// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of DataMem: one request per handshake, fault screening,
// sign/zero extension of load data and a one-cycle registered response.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_is_load,
  output logic              fault,
  output logic              stall,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [1:0]        SaveMethod,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] SM_SB = 2'b00;
  localparam logic [1:0] SM_SH = 2'b01;
  localparam logic [1:0] SM_SW = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic        accept_c;
  logic        oor_c, misalign_c, illegal_c, fault_c;
  logic [31:0] ext_c;

  // Fault screening of the incoming request
  always_comb begin
    oor_c      = (req_addr >> ADDR_W) != 32'd0;
    misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    illegal_c  = req_we ? (req_funct3 > 3'd2)
                        : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    fault_c    = oor_c | misalign_c | illegal_c;
    accept_c   = (state == IDLE) & req_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and DataMem control; MemWrite is gated by rst so a reset never leaves a partial store
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    SaveMethod = SM_SW;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = fault_c ? RESP : ACCESS;
      end
      ACCESS: begin
        MemRead  = ~we_q;
        MemWrite = we_q & ~rst;
        case (funct3_q[1:0])
          2'b00:   SaveMethod = SM_SB;
          2'b01:   SaveMethod = SM_SH;
          default: SaveMethod = SM_SW;
        endcase
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign stall = req_valid & ~req_ready;

  // DataMem already returns the addressed byte in [7:0]; only extension is needed
  always_comb begin
    case (funct3_q)
      3'b000:  ext_c = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b100:  ext_c = {24'd0, mem_rdata[7:0]};
      3'b001:  ext_c = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b101:  ext_c = {16'd0, mem_rdata[15:0]};
      default: ext_c = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_rd      <= 5'd0;
      resp_is_load <= 1'b0;
      fault        <= 1'b0;
    end else begin
      resp_valid <= (state_next == RESP);
      if (accept_c) begin
        we_q         <= req_we;
        funct3_q     <= req_funct3;
        mem_addr     <= req_addr[ADDR_W-1:0];
        mem_wdata    <= req_wdata;
        resp_rd      <= req_rd;
        resp_is_load <= ~req_we;
        fault        <= fault_c;
        resp_rdata   <= 32'd0;
      end
      if ((state == ACCESS) && !we_q) resp_rdata <= ext_c;
    end
  end

endmodule
